// File: rtl/vga_pkg.sv
// Shared definitions for the VGA raster path.
// Holds the default 640x480@60 timing constants, the RGB444 colour record
// and one pixel-word decoder per supported frame-buffer depth.
package vga_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   // RGB332 -> RGB444: replicate the top bits of each field into the LSBs
   function automatic rgb444_t decode_rgb332(input logic [7:0] p);
      rgb444_t c;
      c.r = {p[7:5], p[7]};
      c.g = {p[4:2], p[4]};
      c.b = {p[1:0], p[1:0]};
      return c;
   endfunction

   // RGB444 words map straight onto the output fields
   function automatic rgb444_t decode_rgb444(input logic [11:0] p);
      rgb444_t c;
      c.r = p[11:8];
      c.g = p[7:4];
      c.b = p[3:0];
      return c;
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters for the VGA scan.
// Ports:
//   pxclk, rst_n (sync, active-low), en (low holds counters at 0)
//   h_cnt, v_cnt : current raster position
//   active       : position lies in the visible area
//   hsync, vsync : raw sync windows, active-high, undelayed
//   wrap         : last position of the frame; counters return to (0,0) next
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int H_W     = $clog2(H_TOTAL),
   localparam int V_W     = $clog2(V_TOTAL)
) (
   input  logic           pxclk,
   input  logic           rst_n,
   input  logic           en,
   output logic [H_W-1:0] h_cnt,
   output logic [V_W-1:0] v_cnt,
   output logic           active,
   output logic           hsync,
   output logic           vsync,
   output logic           wrap
);

   localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
   localparam logic [H_W-1:0] H_ACT_C  = H_W'(H_ACTIVE);
   localparam logic [V_W-1:0] V_ACT_C  = V_W'(V_ACTIVE);
   localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
   localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
   localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

   // raster position counters
   always_ff @(posedge pxclk) begin
      if (!rst_n || !en) begin
         h_cnt <= {H_W{1'b0}};
         v_cnt <= {V_W{1'b0}};
      end else if (h_cnt == H_LAST) begin
         h_cnt <= {H_W{1'b0}};
         v_cnt <= (v_cnt == V_LAST) ? {V_W{1'b0}} : v_cnt + V_W'(1);
      end else begin
         h_cnt <= h_cnt + H_W'(1);
         v_cnt <= v_cnt;
      end
   end

   // region decode of the current position
   always_comb begin
      active = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
      hsync  = (h_cnt >= HS_START) && (h_cnt < HS_END);
      vsync  = (v_cnt >= VS_START) && (v_cnt < VS_END);
      wrap   = (h_cnt == H_LAST) && (v_cnt == V_LAST);
   end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA raster generator driving a registered-read frame buffer.
// Optional feature macro: VGA_FRAME_IRQ_EN (frame_irq on entry to vblank).
// Ports:
//   pxclk, rst_n (sync, active-low), en (scan enable, low flushes the scan)
//   px_addr       : pixel index to the frame buffer
//   px_data       : pixel word, valid one pxclk after px_addr
//   vga_r/g/b     : registered RGB444 colour, zero while blanked
//   hsync, vsync  : registered syncs, polarity set by SYNC_ACTIVE_HIGH
//   frame_start   : one-cycle pulse with output pixel (0,0)
//   frame_irq     : sticky vblank flag, cleared by irq_clr
// Output latency is two pxclk from the counter position.
module vga_scan_ctrl
   import vga_pkg::*;
#(
   parameter int H_ACTIVE         = VGA_H_ACTIVE,
   parameter int H_FP             = VGA_H_FP,
   parameter int H_SYNC           = VGA_H_SYNC,
   parameter int H_BP             = VGA_H_BP,
   parameter int V_ACTIVE         = VGA_V_ACTIVE,
   parameter int V_FP             = VGA_V_FP,
   parameter int V_SYNC           = VGA_V_SYNC,
   parameter int V_BP             = VGA_V_BP,
   parameter int PIXEL_DEPTH      = 8,
   parameter int SYNC_ACTIVE_HIGH = 0,
   localparam int A_W             = $clog2(H_ACTIVE * V_ACTIVE)
) (
   input  logic                   pxclk,
   input  logic                   rst_n,
   input  logic                   en,
   output logic [A_W-1:0]         px_addr,
   input  logic [PIXEL_DEPTH-1:0] px_data,
   output logic [3:0]             vga_r,
   output logic [3:0]             vga_g,
   output logic [3:0]             vga_b,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   frame_start,
   output logic                   frame_irq,
   input  logic                   irq_clr
);

   localparam int   H_W      = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam int   V_W      = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
   // deasserted sync level; the delayed active-high sync is XORed with it
   localparam logic SYNC_INV = (SYNC_ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;

   logic [H_W-1:0] h_cnt_s;
   logic [V_W-1:0] v_cnt_s;
   logic           active_s, hs_s, vs_s, wrap_s;
   logic           last_px_s, fs_mark_s;
   logic [A_W-1:0] addr_r;
   logic           act_d1_r, hs_d1_r, vs_d1_r, fs_d1_r;
   rgb444_t        pix_s;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_timing (
      .pxclk  (pxclk),
      .rst_n  (rst_n),
      .en     (en),
      .h_cnt  (h_cnt_s),
      .v_cnt  (v_cnt_s),
      .active (active_s),
      .hsync  (hs_s),
      .vsync  (vs_s),
      .wrap   (wrap_s)
   );

   // position markers used by the address counter and pipeline
   always_comb begin
      last_px_s = (h_cnt_s == H_W'(H_ACTIVE - 1)) && (v_cnt_s == V_W'(V_ACTIVE - 1));
      fs_mark_s = (h_cnt_s == {H_W{1'b0}}) && (v_cnt_s == {V_W{1'b0}});
   end

   // running pixel address; the final visible pixel does not advance it,
   // so the address parks on the last index through vertical blanking
   always_ff @(posedge pxclk) begin
      if (!rst_n || !en) begin
         addr_r <= {A_W{1'b0}};
      end else if (wrap_s) begin
         addr_r <= {A_W{1'b0}};
      end else if (active_s && !last_px_s) begin
         addr_r <= addr_r + A_W'(1);
      end else begin
         addr_r <= addr_r;
      end
   end

   assign px_addr = addr_r;

   // first delay stage, in step with px_data returning from the RAM
   always_ff @(posedge pxclk) begin
      if (!rst_n || !en) begin
         act_d1_r <= 1'b0;
         hs_d1_r  <= 1'b0;
         vs_d1_r  <= 1'b0;
         fs_d1_r  <= 1'b0;
      end else begin
         act_d1_r <= active_s;
         hs_d1_r  <= hs_s;
         vs_d1_r  <= vs_s;
         fs_d1_r  <= fs_mark_s;
      end
   end

   generate
      if (PIXEL_DEPTH == 8) begin : g_rgb332
         // RGB332 pixel decode
         always_comb begin
            pix_s = decode_rgb332(px_data[7:0]);
         end
      end else if (PIXEL_DEPTH == 12) begin : g_rgb444
         // RGB444 pixel decode
         always_comb begin
            pix_s = decode_rgb444(px_data[11:0]);
         end
      end else begin : g_bad_depth
         $error("vga_scan_ctrl: PIXEL_DEPTH must be 8 or 12");
         // constant drive for the unsupported configuration
         always_comb begin
            pix_s = rgb444_t'(12'h000);
         end
      end
   endgenerate

   // output stage: colour blanked by the delayed active flag, syncs polarised
   always_ff @(posedge pxclk) begin
      if (!rst_n || !en) begin
         vga_r       <= 4'h0;
         vga_g       <= 4'h0;
         vga_b       <= 4'h0;
         hsync       <= SYNC_INV;
         vsync       <= SYNC_INV;
         frame_start <= 1'b0;
      end else begin
         vga_r       <= act_d1_r ? pix_s.r : 4'h0;
         vga_g       <= act_d1_r ? pix_s.g : 4'h0;
         vga_b       <= act_d1_r ? pix_s.b : 4'h0;
         hsync       <= hs_d1_r ^ SYNC_INV;
         vsync       <= vs_d1_r ^ SYNC_INV;
         frame_start <= fs_d1_r;
      end
   end

`ifdef VGA_FRAME_IRQ_EN
   logic irq_mark_s, irq_d1_r, frame_irq_r;

   // (0, V_ACTIVE) marks entry to vertical blanking
   always_comb begin
      irq_mark_s = (h_cnt_s == {H_W{1'b0}}) && (v_cnt_s == V_W'(V_ACTIVE));
   end

   // vblank marker delayed to meet the output stage
   always_ff @(posedge pxclk) begin
      if (!rst_n || !en) begin
         irq_d1_r <= 1'b0;
      end else begin
         irq_d1_r <= irq_mark_s;
      end
   end

   // sticky flag; a set in the same cycle as a clear wins
   always_ff @(posedge pxclk) begin
      if (!rst_n) begin
         frame_irq_r <= 1'b0;
      end else if (irq_d1_r) begin
         frame_irq_r <= 1'b1;
      end else if (irq_clr) begin
         frame_irq_r <= 1'b0;
      end else begin
         frame_irq_r <= frame_irq_r;
      end
   end

   assign frame_irq = frame_irq_r;
`else
   logic unused_irq_clr;
   assign unused_irq_clr = irq_clr;
   assign frame_irq      = 1'b0;
`endif

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Bench for vga_scan_ctrl using a reduced raster (16x12 visible, 32x19 total)
// so several whole frames fit in a short run. The frame buffer is a one-cycle
// registered RAM model returning px_addr[7:0], or 8'hFF in blanking mode.
module tb_vga_scan_ctrl;

   localparam int HA = 16, HF = 4, HS = 6, HB = 6, HT = 32;
   localparam int VA = 12, VF = 2, VS = 2, VB = 3, VT = 19;
   localparam int FR = HT * VT;
   localparam int AW = 8;

   logic          pxclk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b1;
   logic          irq_clr = 1'b0;
   logic [AW-1:0] px_addr;
   logic [7:0]    px_data = 8'h00;
   logic [3:0]    vga_r, vga_g, vga_b;
   logic          hsync, vsync, frame_start, frame_irq;
   logic          ff_mode = 1'b0;

   int checks = 0;
   int errors = 0;
   int out_idx = -2;

   vga_scan_ctrl #(
      .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .PIXEL_DEPTH (8), .SYNC_ACTIVE_HIGH (0)
   ) dut (
      .pxclk (pxclk), .rst_n (rst_n), .en (en),
      .px_addr (px_addr), .px_data (px_data),
      .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
      .hsync (hsync), .vsync (vsync), .frame_start (frame_start),
      .frame_irq (frame_irq), .irq_clr (irq_clr)
   );

   always #5 pxclk = ~pxclk;

   // registered-read frame buffer model
   always @(posedge pxclk) begin
      px_data <= ff_mode ? 8'hFF : px_addr;
   end

   typedef struct {
      int         h;
      int         v;
      int         f;
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
      logic       hs;
      logic       vs;
      logic       fs;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (out_idx %0d)", name, act, exp, out_idx);
      end
   endtask

   function automatic logic [14:0] outs();
      return {vga_r, vga_g, vga_b, hsync, vsync, frame_start};
   endfunction

   // expected px_addr when the counters sit at frame position p
   function automatic int exp_addr(input int p);
      int q, h, v;
      q = p % FR;
      h = q % HT;
      v = q / HT;
      if (v < VA && h < HA) return v * HA + h;
      if (v < VA - 1) return (v + 1) * HA;
      return VA * HA - 1;
   endfunction

   task automatic tick();
      @(posedge pxclk);
      #1;
      out_idx++;
   endtask

   // advance until the output stage shows position idx, checking px_addr
   task automatic adv_to(input int idx);
      while (out_idx < idx) begin
         tick();
         check("px_addr", 32'(px_addr), 32'(exp_addr(out_idx + 2)));
      end
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      en      = 1'b1;
      irq_clr = 1'b0;
      repeat (3) @(posedge pxclk);
      #1;
   endtask

   task automatic release_reset();
      rst_n   = 1'b1;
      out_idx = -2;
   endtask

   // abort the scan at counter position (10,5) using en or rst_n
   task automatic mid_abort(input bit use_rst, input string tag);
      ff_mode = 1'b0;
      do_reset();
      release_reset();
      adv_to(5 * HT + 10 - 2);
      if (use_rst) rst_n = 1'b0;
      else en = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(posedge pxclk);
         #1;
         check({tag, "_gap"}, {15'(outs()), px_addr, frame_irq},
               {4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0});
      end
      rst_n   = 1'b1;
      en      = 1'b1;
      out_idx = -2;
      tick();
      check({tag, "_fs_early"}, 32'(frame_start), 32'(1'b0));
      tick();
      check({tag, "_fs"}, 32'(outs()), 32'({12'h000, 1'b1, 1'b1, 1'b1}));
      adv_to(5);
      check({tag, "_px5"}, 32'(outs()), 32'({4'h0, 4'h2, 4'h5, 1'b1, 1'b1, 1'b0}));
   endtask

   initial begin
      int   hs_fall, hs_low, vs_fall, vs_low, n_hs_fall, n_vs_fall;
      logic hs_prev, vs_prev;
      bit   act;

      vecs[0]  = '{0,  0,  0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1};
      vecs[1]  = '{5,  0,  0, 4'h0, 4'h2, 4'h5, 1'b1, 1'b1, 1'b0};
      vecs[2]  = '{15, 0,  0, 4'h0, 4'h6, 4'hF, 1'b1, 1'b1, 1'b0};
      vecs[3]  = '{16, 0,  0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
      vecs[4]  = '{20, 0,  0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{25, 0,  0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0};
      vecs[6]  = '{26, 0,  0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
      vecs[7]  = '{0,  1,  0, 4'h0, 4'h9, 4'h0, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{3,  2,  0, 4'h2, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{15, 11, 0, 4'hB, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{16, 11, 0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
      vecs[11] = '{0,  14, 0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{22, 14, 0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{31, 15, 0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{0,  16, 0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0};
      vecs[15] = '{0,  0,  1, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1};
      vecs[16] = '{7,  0,  1, 4'h0, 4'h2, 4'hF, 1'b1, 1'b1, 1'b0};

      // reset state
      do_reset();
      check("reset_outs", 32'(outs()), 32'({12'h000, 1'b1, 1'b1, 1'b0}));
      check("reset_addr", 32'(px_addr), 32'h0);
      check("reset_irq", 32'(frame_irq), 32'h0);

      // addressing, decode, sync placement, frame wrap
      release_reset();
      for (int i = 0; i < 17; i++) begin
         adv_to(vecs[i].f * FR + vecs[i].v * HT + vecs[i].h);
         check($sformatf("vec%0d", i), 32'(outs()),
               32'({vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].hs, vecs[i].vs, vecs[i].fs}));
      end

      // blanking with all-ones pixels plus line/frame timing over two frames
      ff_mode = 1'b1;
      adv_to(2 * FR - 1);
      hs_fall = -1; vs_fall = -1; hs_low = 0; vs_low = 0;
      n_hs_fall = 0; n_vs_fall = 0;
      hs_prev = hsync; vs_prev = vsync;
      for (int i = 2 * FR; i < 4 * FR; i++) begin
         adv_to(i);
         act = ((i % FR) % HT < HA) && ((i % FR) / HT < VA);
         check("blank_rgb", 32'({vga_r, vga_g, vga_b}), act ? 32'hFFF : 32'h000);
         if (!hsync) hs_low++;
         if (!vsync) vs_low++;
         if (hs_prev && !hsync) begin
            if (hs_fall >= 0) check("hs_period", 32'(i - hs_fall), 32'(HT));
            hs_fall = i;
            n_hs_fall++;
         end
         if (!hs_prev && hsync) begin
            check("hs_low", 32'(hs_low), 32'(HS));
            hs_low = 0;
         end
         if (vs_prev && !vsync) begin
            if (vs_fall >= 0) check("vs_period", 32'(i - vs_fall), 32'(FR));
            vs_fall = i;
            n_vs_fall++;
         end
         if (!vs_prev && vsync) begin
            check("vs_low", 32'(vs_low), 32'(VS * HT));
            vs_low = 0;
         end
         hs_prev = hsync;
         vs_prev = vsync;
      end
      check("hs_fall_count", 32'(n_hs_fall), 32'(2 * VT));
      check("vs_fall_count", 32'(n_vs_fall), 32'(2));

      // mid-frame abort by enable, then by reset
      mid_abort(1'b0, "en_abort");
      mid_abort(1'b1, "rst_abort");

      // frame interrupt
      do_reset();
      release_reset();
      adv_to(VA * HT - 1);
      check("irq_before", 32'(frame_irq), 32'h0);
      adv_to(VA * HT);
`ifdef VGA_FRAME_IRQ_EN
      check("irq_set", 32'(frame_irq), 32'h1);
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      check("irq_clr", 32'(frame_irq), 32'h0);
      tick();
      check("irq_stays_clr", 32'(frame_irq), 32'h0);
      adv_to(FR + VA * HT - 1);
      check("irq_before2", 32'(frame_irq), 32'h0);
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      check("irq_set_wins", 32'(frame_irq), 32'h1);
      tick();
      check("irq_hold", 32'(frame_irq), 32'h1);
`else
      check("irq_off", 32'(frame_irq), 32'h0);
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      check("irq_off_clr", 32'(frame_irq), 32'h0);
      adv_to(FR + VA * HT);
      check("irq_off2", 32'(frame_irq), 32'h0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
